// File: rtl/bcd2_counter_pkg.sv
// Shared types and constants for the two-digit BCD counter.
package bcd2_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_DIGIT_MAX = 4'd9;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when a 4-bit nibble holds a legal decimal digit.
    function automatic logic bcd_valid(input bcd_t d);
        return (d <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd2_counter_bcd_digit.sv
// Single BCD digit register: increments/decrements on cnt_i and
// reports carry (up) or borrow (down) out to the next digit.
// A load overrides counting.
module bcd_digit
    import bcd2_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic cnt_i,
    input  logic up_i,
    output logic cout_o,
    output bcd_t digit_o
);

    bcd_t digit_q, digit_d;

    // Next digit value: load first, then inc/dec with 9<->0 rollover.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (cnt_i) begin
            if (up_i == DIR_UP) begin
                digit_d = (digit_q == BCD_DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? BCD_DIGIT_MAX : digit_q - 4'd1;
            end
        end
    end

    // Carry/borrow fires when this digit rolls over on a count.
    always_comb begin
        cout_o = cnt_i & ~load_i &
                 ((up_i == DIR_UP) ? (digit_q == BCD_DIGIT_MAX) : (digit_q == 4'd0));
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) digit_q <= 4'd0;
        else     digit_q <= digit_d;
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter with prescaler and checked parallel load.
// Optional build macro: BCD2_COUNTER_SATURATE_EN -- when defined the
// value holds at the limits instead of wrapping (tc still pulses).
module bcd2_counter
    import bcd2_counter_pkg::*;
#(
    parameter int PRESCALE = 50000000,
    parameter int MAX_VAL  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] d1In,
    input  logic [3:0] d0In,
    output logic [3:0] a1Out,
    output logic [3:0] a0Out,
    output logic       tc,
    output logic       load_err
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam bcd_t          MAX_TENS   = bcd_t'(MAX_VAL / 10);
    localparam bcd_t          MAX_UNITS  = bcd_t'(MAX_VAL % 10);
    localparam logic [7:0]    MAX_DEC    = 8'(MAX_VAL);

    logic [PW-1:0] presc_q, presc_d;
    logic          tc_q, tc_d;
    logic          err_q, err_d;

    bcd_t       tens, units;
    logic       step, step_eff, at_limit, wrap;
    logic [7:0] load_dec;
    logic       load_ok, load_acc, load_rej;
    logic       digit_load, units_cnt, units_cout;
    bcd_t       tens_ld, units_ld;

    // Step condition and load qualification.
    always_comb begin
        step     = en & (presc_q == PRESC_LAST);
        load_dec = {4'b0, d1In} * 8'd10 + {4'b0, d0In};
        load_ok  = bcd_valid(d1In) & bcd_valid(d0In) & (load_dec <= MAX_DEC);
        load_acc = load & load_ok;
        load_rej = load & ~load_ok;
        // An accepted load wins; the coincident step is dropped.
        step_eff = step & ~load_acc;
        at_limit = (up_dn == DIR_UP) ? ((tens == MAX_TENS) && (units == MAX_UNITS))
                                     : ((tens == 4'd0) && (units == 4'd0));
        wrap     = step_eff & at_limit;
        // Normal inc/dec only away from the limit; the limit is handled below.
        units_cnt = step_eff & ~at_limit;
    end

    // Digit load source: external data, or the wrap target value.
    always_comb begin
`ifdef BCD2_COUNTER_SATURATE_EN
        digit_load = load_acc;
        tens_ld    = d1In;
        units_ld   = d0In;
`else
        digit_load = load_acc | wrap;
        if (load_acc) begin
            tens_ld  = d1In;
            units_ld = d0In;
        end else if (up_dn == DIR_UP) begin
            tens_ld  = 4'd0;
            units_ld = 4'd0;
        end else begin
            tens_ld  = MAX_TENS;
            units_ld = MAX_UNITS;
        end
`endif
    end

    // Prescaler next state: cleared by accepted load or step, frozen when en=0.
    always_comb begin
        presc_d = presc_q;
        if (load_acc)  presc_d = '0;
        else if (step) presc_d = '0;
        else if (en)   presc_d = presc_q + 1'b1;
    end

    // One-cycle status pulses.
    always_comb begin
        tc_d  = wrap;
        err_d = load_rej;
    end

    // Prescaler and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    bcd_digit u_units (
        .clk       (clk),
        .rst       (rst),
        .load_i    (digit_load),
        .load_val_i(units_ld),
        .cnt_i     (units_cnt),
        .up_i      (up_dn),
        .cout_o    (units_cout),
        .digit_o   (units)
    );

    // The tens carry-out is never needed: the top-level limit logic
    // intercepts counting before the tens digit could roll over.
    logic tens_cout;

    bcd_digit u_tens (
        .clk       (clk),
        .rst       (rst),
        .load_i    (digit_load),
        .load_val_i(tens_ld),
        .cnt_i     (units_cout),
        .up_i      (up_dn),
        .cout_o    (tens_cout),
        .digit_o   (tens)
    );

    assign a1Out    = tens;
    assign a0Out    = units;
    assign tc       = tc_q;
    assign load_err = err_q;

    logic unused_ok;
    assign unused_ok = tens_cout;

endmodule
